// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the four-digit 7-segment display block.
//   digit_t      4-bit decimal digit code (0..9 valid; 10..15 decode to blank)
//   SEG_0..SEG_9 segment patterns in active-low form, bit[0]=a .. bit[6]=g
//   SEG_BLANK    all segments off (active-low form)
//   NUM_DIGITS   number of displayed digits
package seg7_pkg;
  typedef logic [3:0] digit_t;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Code fed to a decoder to force a blank digit.
  localparam digit_t DIGIT_BLANK = 4'hF;
endpackage

// File: rtl/four_seven_segment_if.sv
// four_seven_segment_if: value in / segment patterns out for four_seven_segment.
//   bcd        10-bit unsigned binary value to display
//   u_segment  units segments     (bit[0]=a .. bit[6]=g)
//   d_segment  tens segments
//   h_segment  hundreds segments
//   t_segment  thousands segments
// Modports: master drives bcd and reads segments; slave is the display block.
interface four_seven_segment_if;
  logic [9:0] bcd;
  logic [6:0] u_segment;
  logic [6:0] d_segment;
  logic [6:0] h_segment;
  logic [6:0] t_segment;

  modport master (output bcd, input u_segment, d_segment, h_segment, t_segment);
  modport slave  (input bcd, output u_segment, d_segment, h_segment, t_segment);
endinterface

// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder: combinational digit -> 7-segment pattern.
//   digit    in  4  digit code; 0..9 shown, 10..15 blank
//   pattern  out 7  segments, bit[0]=a .. bit[6]=g
// ACTIVE_LOW=1: lit segment driven 0; ACTIVE_LOW=0: lit segment driven 1.
module seven_segment_decoder
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  digit_t     digit,
  output logic [6:0] pattern
);
  logic [6:0] pat_al;

  always_comb begin
    pat_al = SEG_BLANK;
    unique case (digit)
      4'd0:    pat_al = SEG_0;
      4'd1:    pat_al = SEG_1;
      4'd2:    pat_al = SEG_2;
      4'd3:    pat_al = SEG_3;
      4'd4:    pat_al = SEG_4;
      4'd5:    pat_al = SEG_5;
      4'd6:    pat_al = SEG_6;
      4'd7:    pat_al = SEG_7;
      4'd8:    pat_al = SEG_8;
      4'd9:    pat_al = SEG_9;
      default: pat_al = SEG_BLANK;
    endcase
  end

  assign pattern = ACTIVE_LOW ? pat_al : ~pat_al;
endmodule

// File: rtl/four_seven_segment.sv
// four_seven_segment: 10-bit binary value -> four registered 7-segment digits.
//   clk  in  system clock, rising edge
//   rst  in  synchronous active-high reset; outputs go to all-segments-off
//   seg  slave modport of four_seven_segment_if (bcd in, u/d/h/t_segment out)
// Binary-to-BCD is combinational shift-add-3; the only register is the
// output stage, so latency is one clock.
// Optional macro LEADING_ZERO_BLANK_EN: blank leading zero digits (units never blanked).
module four_seven_segment
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  four_seven_segment_if.slave   seg
);
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

  // Digit index 0=units .. 3=thousands.
  digit_t [NUM_DIGITS-1:0]  dig;
  digit_t [NUM_DIGITS-1:0]  dig_show;
  logic   [NUM_DIGITS-1:0][6:0] pat;
  logic   [NUM_DIGITS-1:0][6:0] seg_q;

  // Double dabble: 16 BCD bits above the 10 binary bits; correct each
  // digit >=5 before every shift so it carries correctly into the next.
  logic [25:0] sr;
  always_comb begin
    sr = {16'd0, seg.bcd};
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < NUM_DIGITS; j++) begin
        if (sr[10+4*j +: 4] >= 4'd5)
          sr[10+4*j +: 4] = sr[10+4*j +: 4] + 4'd3;
      end
      sr = sr << 1;
    end
    dig = sr[25:10];
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every more significant digit are zero.
  logic [NUM_DIGITS-1:0] blank;
  always_comb begin
    blank    = '0;
    dig_show = dig;
    blank[3] = (dig[3] == 4'd0);
    blank[2] = blank[3] && (dig[2] == 4'd0);
    blank[1] = blank[2] && (dig[1] == 4'd0);
    for (int k = 1; k < NUM_DIGITS; k++)
      if (blank[k]) dig_show[k] = DIGIT_BLANK;
  end
`else
  assign dig_show = dig;
`endif

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seven_segment_decoder #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
      .digit   (dig_show[g]),
      .pattern (pat[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) seg_q <= {NUM_DIGITS{SEG_OFF}};
    else     seg_q <= pat;
  end

  assign seg.u_segment = seg_q[0];
  assign seg.d_segment = seg_q[1];
  assign seg.h_segment = seg_q[2];
  assign seg.t_segment = seg_q[3];
endmodule

// File: tb/tb_four_seven_segment.sv
// tb_four_seven_segment: self-checking bench for four_seven_segment (ACTIVE_LOW=1).
// Fixed vectors from the display rules, random and exhaustive values against
// an arithmetic digit model, and reset sequences.
// Honours LEADING_ZERO_BLANK_EN when compiled with it.
module tb_four_seven_segment;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  four_seven_segment_if sif ();

  four_seven_segment #(.ACTIVE_LOW(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .seg (sif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          v;
    logic [27:0] exp;   // {t,h,d,u}
  } vec_t;

  localparam logic [6:0] OFF = 7'h7F;
  logic [6:0] seg_tab [10];

  // Reference: decimal digits by division, pattern by table lookup.
  function automatic logic [27:0] model(input int v);
    int t, h, d, u;
    logic [6:0] pt, ph, pd, pu;
    t = v / 1000;
    h = (v / 100) % 10;
    d = (v / 10) % 10;
    u = v % 10;
    pt = seg_tab[t]; ph = seg_tab[h]; pd = seg_tab[d]; pu = seg_tab[u];
`ifdef LEADING_ZERO_BLANK_EN
    if (v < 1000) pt = OFF;
    if (v < 100)  ph = OFF;
    if (v < 10)   pd = OFF;
`endif
    return {pt, ph, pd, pu};
  endfunction

  function automatic logic [27:0] got();
    return {sif.t_segment, sif.h_segment, sif.d_segment, sif.u_segment};
  endfunction

  task automatic check(input string name, input logic [27:0] exp);
    logic [27:0] g;
    g = got();
    checks++;
    if (g !== exp) begin
      errors++;
      $display("FAIL %s: got t=%h h=%h d=%h u=%h expected t=%h h=%h d=%h u=%h",
               name, g[27:21], g[20:14], g[13:7], g[6:0],
               exp[27:21], exp[20:14], exp[13:7], exp[6:0]);
    end
  endtask

  // Apply inputs away from the edge, then sample just after the edge.
  task automatic step(input logic r, input int v);
    @(negedge clk);
    rst = r;
    sif.bcd = v[9:0];
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    rst = 1'b1;
    sif.bcd = 10'd0;

    // Reset held two cycles: blank, even with a nonzero input.
    step(1'b1, 1023);
    check("reset_c1", {4{OFF}});
    step(1'b1, 555);
    check("reset_c2", {4{OFF}});

    // First edge with rst low shows the value sampled on that edge.
`ifdef LEADING_ZERO_BLANK_EN
    step(1'b0, 0);
    check("release_0", {OFF, OFF, OFF, 7'h40});
`else
    step(1'b0, 0);
    check("release_0", {7'h40, 7'h40, 7'h40, 7'h40});
`endif

`ifdef LEADING_ZERO_BLANK_EN
    vecs.push_back('{9,    {OFF, OFF, OFF, 7'h10}});
    vecs.push_back('{0,    {OFF, OFF, OFF, 7'h40}});
    vecs.push_back('{1005, {7'h79, 7'h40, 7'h40, 7'h12}});
    vecs.push_back('{99,   {OFF, OFF, 7'h10, 7'h10}});
    vecs.push_back('{1023, {7'h79, 7'h40, 7'h24, 7'h30}});
`else
    vecs.push_back('{9,    {7'h40, 7'h40, 7'h40, 7'h10}});
    vecs.push_back('{99,   {7'h40, 7'h40, 7'h10, 7'h10}});
    vecs.push_back('{999,  {7'h40, 7'h10, 7'h10, 7'h10}});
    vecs.push_back('{1023, {7'h79, 7'h40, 7'h24, 7'h30}});
    vecs.push_back('{0,    {7'h40, 7'h40, 7'h40, 7'h40}});
    vecs.push_back('{1005, {7'h79, 7'h40, 7'h40, 7'h12}});
`endif
    foreach (vecs[i]) begin
      step(1'b0, vecs[i].v);
      check($sformatf("vec_%0d", vecs[i].v), vecs[i].exp);
    end

    // Random values, a new one every cycle.
    for (int i = 0; i < 300; i++) begin
      int v;
      v = int'($urandom_range(1023, 0));
      step(1'b0, v);
      check($sformatf("rand_%0d", v), model(v));
    end

    // Exhaustive sweep.
    for (int v = 0; v < 1024; v++) begin
      step(1'b0, v);
      check($sformatf("sweep_%0d", v), model(v));
    end

    // Reset mid-stream while bcd=1023: blank on that edge, resume one cycle later.
    step(1'b0, 1023);
    check("pre_rst_1023", model(1023));
    step(1'b1, 1023);
    check("mid_rst_1023", {4{OFF}});
    step(1'b1, 1023);
    check("mid_rst_hold", {4{OFF}});
    step(1'b0, 1023);
    check("resume_1023", model(1023));
    step(1'b0, 47);
    check("resume_next", model(47));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
